// File: rtl/ram_bus_arbiter.sv
// ram_bus_arbiter: shares one RAM port among CPUS cores, each with an
// instruction-read source and a data read/write source. Round-robin across
// cores, data before instruction within a core, write before read.
module ram_bus_arbiter #(
  parameter int CPUS = 2,
  parameter int CW   = (CPUS > 1) ? $clog2(CPUS) : 1
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [CPUS-1:0]        iREN,
  input  logic [CPUS-1:0][31:0]  iaddr,
  input  logic [CPUS-1:0]        dREN,
  input  logic [CPUS-1:0]        dWEN,
  input  logic [CPUS-1:0][31:0]  daddr,
  input  logic [CPUS-1:0][31:0]  dstore,
  output logic [CPUS-1:0]        iwait,
  output logic [CPUS-1:0]        dwait,
  output logic [CPUS-1:0][31:0]  iload,
  output logic [CPUS-1:0][31:0]  dload,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [31:0]            ramaddr,
  output logic [31:0]            ramstore,
  input  logic [1:0]             ramstate,
  input  logic [31:0]            ramload
);

  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   rr_q, rr_d;
  logic [CW-1:0]   core_q, core_d;
  logic            isd_q, isd_d;      // granted source is the data port
  logic            wflag_q, wflag_d;  // granted transaction is a write
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     store_q, store_d;

  logic            done;
  logic            greq;
  logic            found;
  logic [CW:0]     scan_sum;
  logic [CW-1:0]   scan_idx;

  // Core following c in round-robin order (wraps at CPUS-1).
  function automatic logic [CW-1:0] next_core(input logic [CW-1:0] c);
    if (int'(c) >= CPUS - 1) return '0;
    else return c + 1'b1;
  endfunction

  // The granted requester still wants service; the RAM completes this cycle.
  assign greq = isd_q ? (dREN[core_q] | dWEN[core_q]) : iREN[core_q];
  assign done = (state_q == ACCESS) && (ramstate == RAM_ACCESS);

  // RAM port driven from the latched grant; enables only while in ACCESS.
  assign ramREN   = (state_q == ACCESS) && !wflag_q;
  assign ramWEN   = (state_q == ACCESS) &&  wflag_q;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;

  // Per-core waits fall for the single cycle the granted source completes.
  always_comb begin
    for (int c = 0; c < CPUS; c++) begin
      iwait[c] = iREN[c] & ~(done & ~isd_q & (core_q == CW'(c)));
      dwait[c] = (dREN[c] | dWEN[c]) & ~(done & isd_q & (core_q == CW'(c)));
      iload[c] = ramload;
      dload[c] = ramload;
    end
  end

  // Arbitration scan in IDLE and completion/abort handling in ACCESS.
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    core_d   = core_q;
    isd_d    = isd_q;
    wflag_d  = wflag_q;
    addr_d   = addr_q;
    store_d  = store_q;
    found    = 1'b0;
    scan_sum = '0;
    scan_idx = '0;
    case (state_q)
      IDLE: begin
        for (int k = 0; k < CPUS; k++) begin
          scan_sum = {1'b0, rr_q} + (CW+1)'(k);
          if (scan_sum >= (CW+1)'(CPUS)) scan_sum = scan_sum - (CW+1)'(CPUS);
          scan_idx = scan_sum[CW-1:0];
          if (!found && (dREN[scan_idx] | dWEN[scan_idx] | iREN[scan_idx])) begin
            found   = 1'b1;
            state_d = ACCESS;
            core_d  = scan_idx;
            store_d = dstore[scan_idx];
            if (dREN[scan_idx] | dWEN[scan_idx]) begin
              isd_d   = 1'b1;
              wflag_d = dWEN[scan_idx];
              addr_d  = daddr[scan_idx];
            end else begin
              isd_d   = 1'b0;
              wflag_d = 1'b0;
              addr_d  = iaddr[scan_idx];
            end
          end
        end
      end
      ACCESS: begin
        // Completion or abort both release the port and advance the pointer.
        if (done || !greq) begin
          state_d = IDLE;
          rr_d    = next_core(core_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and grant registers; reset returns to IDLE with the port cleared.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      rr_q    <= '0;
      core_q  <= '0;
      isd_q   <= 1'b0;
      wflag_q <= 1'b0;
      addr_q  <= '0;
      store_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      core_q  <= core_d;
      isd_q   <= isd_d;
      wflag_q <= wflag_d;
      addr_q  <= addr_d;
      store_q <= store_d;
    end
  end

endmodule

// File: doc/ram_bus_arbiter.md
Name: ram_bus_arbiter

Overview:
- Sits between the per-core cache/fetch request ports and the single shared RAM port; sequences every RAM transaction.
- Arbitrates among CPUS cores, each with one instruction-read source and one data read/write source.
- Registers the winning request and holds it on the RAM port until the RAM reports ACCESS, then returns load data and releases the matching wait.
- Round-robin across cores; within a core, data has priority over instruction.

Parameters:
- CPUS, 2, number of cores; legal range 1..4.
- CW, $clog2(CPUS) (min 1), width of the core-index and round-robin pointer.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- iREN  in  CPUS  instruction read request, per core.
- iaddr  in  CPUS x 32  instruction address, per core.
- dREN  in  CPUS  data read request, per core.
- dWEN  in  CPUS  data write request, per core.
- daddr  in  CPUS x 32  data address, per core.
- dstore  in  CPUS x 32  data write value, per core.
- iwait  out  CPUS  instruction stall, per core.
- dwait  out  CPUS  data stall, per core.
- iload  out  CPUS x 32  instruction return data.
- dload  out  CPUS x 32  data return data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- ramload  in  32  RAM read data.

Behaviour:
- Clock/reset: one clock CLK; reset nRST is asynchronous, active-low.
- Reset state: IDLE; rr_ptr=0; grant registers 0; ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
- During and after reset, waits are combinational: iwait[c]=iREN[c]&~idone[c]; dwait[c]=(dREN[c]|dWEN[c])&~ddone[c].
- iload[c]=ramload and dload[c]=ramload for every core (consumers sample only when their wait is low).
- FSM states: IDLE, ACCESS.
- IDLE scan order: cores rr_ptr, rr_ptr+1, ... mod CPUS. The first core with any request wins.
  - For that core: data request beats instruction request.
  - dWEN beats dREN when both are high (treated as a write).
- IDLE grant: latch core id, type (I/D), write flag, address, and store data; go to ACCESS on the next edge.
  - No requests: stay IDLE; rr_ptr unchanged.
- ACCESS outputs: ramaddr and ramstore come from the latched values; ramREN=~wflag; ramWEN=wflag.
- ACCESS completion: when ramstate==ACCESS, assert done for the granted source this cycle (idone or ddone, one bit only). Its wait drops low for exactly one cycle.
  - Next edge: go to IDLE and set rr_ptr=(granted core+1) mod CPUS.
- ACCESS hold: while ramstate is BUSY, FREE, or ERROR, stay in ACCESS with the RAM signals held stable. ERROR is treated as BUSY (retry).
- Abort: if the granted request signal (iREN, dREN/dWEN per latched type) is deasserted while in ACCESS, return to IDLE next edge.
  - No done is asserted; ramREN/ramWEN drop with the state change; rr_ptr still advances.
- Latency: grant edge plus at least one ACCESS cycle, so a request raised at cycle 0 with RAM returning ACCESS immediately sees wait low in cycle 1. The return-to-IDLE cycle adds one more, so the minimum back-to-back spacing is 2 cycles per transaction.
- Request change during ACCESS: a change of address or store data by the granted requester is ignored (latched values are used).
- Non-granted requesters: their waits stay high throughout.
- Reset mid-operation: immediately returns to IDLE with all RAM enables 0; no done is produced.
- CPUS=1: the rr_ptr is constant 0.

Test Plan:
- Single fetch: core0 iREN=1, iaddr=0x0004; RAM BUSY 2 cycles then ACCESS, ramload=0xDEADBEEF -> ramREN=1, ramaddr=0x0004 from cycle 1; iwait[0]=0 and iload[0]=0xDEADBEEF in cycle 3 only; ramREN=0 in cycle 4.
- Same-core priority: core0 iREN=1 (iaddr 0x0010) and dREN=1 (daddr 0x0100) together -> first RAM access at 0x0100; dwait[0] drops first, then fetch of 0x0010 is granted.
- Round-robin: core0 and core1 dWEN=1 continuously, daddr 0x0040/0x0080, dstore 0x11111111/0x22222222, RAM returns ACCESS immediately -> ramWEN transactions alternate core0, core1, core0 with matching ramaddr/ramstore; no core is granted twice in a row.
- Read+write conflict: core1 dREN=1 and dWEN=1, daddr 0x0200, dstore 0xCAFEF00D -> ramWEN=1, ramREN=0, ramstore=0xCAFEF00D.
- Abort: core0 dREN at 0x0300, RAM BUSY; drop dREN after 2 ACCESS cycles -> next edge IDLE, ramREN=0, dwait[0] never pulsed low while dREN was high; a pending core1 request is granted next.
- Reset mid-access: assert nRST=0 asynchronously during BUSY -> ramREN/ramWEN=0 without waiting for a clock; after release, rr_ptr=0 and core0 wins a simultaneous core0/core1 request.
